// File: rtl/idu_issue_scoreboard.sv
// Decode-to-execute issue stage with a per-register pending-write scoreboard.
// Optional macro WB_BYPASS_EN: hazard check sees same-cycle writeback retires.
module idu_issue_scoreboard #(
    parameter int GPR_AW    = 5,
    parameter int CSR_AW    = 2,
    parameter int NUM_WB    = 2,
    parameter int PEND_W    = 2,
    parameter int PAYLOAD_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_W-1:0]     in_payload,
    input  logic [GPR_AW-1:0]        in_rs1,
    input  logic [GPR_AW-1:0]        in_rs2,
    input  logic                     in_rs1_used,
    input  logic                     in_rs2_used,
    input  logic [GPR_AW-1:0]        in_rd,
    input  logic                     in_rd_we,
    input  logic [CSR_AW-1:0]        in_csr_rs,
    input  logic                     in_csr_rs_used,
    input  logic [CSR_AW-1:0]        in_csr_rd,
    input  logic                     in_csr_we,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_W-1:0]     out_payload,
    output logic [GPR_AW-1:0]        out_rd,
    output logic                     out_rd_we,
    output logic [CSR_AW-1:0]        out_csr_rd,
    output logic                     out_csr_we,
    input  logic [NUM_WB-1:0]        wb_gpr_valid,
    input  logic [NUM_WB*GPR_AW-1:0] wb_gpr_rd,
    input  logic [NUM_WB-1:0]        wb_csr_valid,
    input  logic [NUM_WB*CSR_AW-1:0] wb_csr_rd,
    input  logic                     flush,
    output logic                     sb_busy,
    output logic                     sb_error,
    output logic [31:0]              stall_cycles
);
    localparam int NUM_GPR = 2**GPR_AW;
    localparam int NUM_CSR = 2**CSR_AW;
    localparam int DEC_W   = $clog2(NUM_WB + 1);
    localparam int SUM_W   = PEND_W + DEC_W + 1;
    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID} state_t;

    state_t                r_state;
    logic                  r_outValid;
    logic [PAYLOAD_W-1:0]  r_payload;
    logic [GPR_AW-1:0]     r_rs1, r_rs2, r_rd;
    logic                  r_rs1Used, r_rs2Used, r_rdWe;
    logic [CSR_AW-1:0]     r_csrRs, r_csrRd;
    logic                  r_csrRsUsed, r_csrWe;
    logic [PEND_W-1:0]     r_gprCnt [NUM_GPR];
    logic [PEND_W-1:0]     r_csrCnt [NUM_CSR];
    logic                  r_sbBusy, r_sbError;
    logic [31:0]           r_stallCycles;

    logic [DEC_W-1:0]      w_gprDec  [NUM_GPR];
    logic [DEC_W-1:0]      w_csrDec  [NUM_CSR];
    logic [SUM_W-1:0]      w_gprSum  [NUM_GPR];
    logic [SUM_W-1:0]      w_csrSum  [NUM_CSR];
    logic [PEND_W-1:0]     w_gprNext [NUM_GPR];
    logic [PEND_W-1:0]     w_csrNext [NUM_CSR];
    logic [PEND_W-1:0]     w_gprEff  [NUM_GPR];
    logic [PEND_W-1:0]     w_csrEff  [NUM_CSR];
    logic                  w_underflow, w_anyNext, w_hazard;
    logic                  w_issue, w_inReady, w_capture;

    assign w_issue   = (r_state == S_VALID) && out_ready && !flush;
    assign w_inReady = !rst && !flush && ((r_state == S_IDLE) || ((r_state == S_VALID) && out_ready));
    assign w_capture = in_valid && w_inReady;

    // Count how many writeback channels retire each register this cycle; GPR 0 is untracked.
    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) begin
            w_gprDec[i] = '0;
            for (int c = 0; c < NUM_WB; c++)
                if (i != 0 && wb_gpr_valid[c] && wb_gpr_rd[c*GPR_AW +: GPR_AW] == GPR_AW'(i))
                    w_gprDec[i] = w_gprDec[i] + DEC_W'(1);
        end
        for (int i = 0; i < NUM_CSR; i++) begin
            w_csrDec[i] = '0;
            for (int c = 0; c < NUM_WB; c++)
                if (wb_csr_valid[c] && wb_csr_rd[c*CSR_AW +: CSR_AW] == CSR_AW'(i))
                    w_csrDec[i] = w_csrDec[i] + DEC_W'(1);
        end
    end

    always_comb begin
        w_underflow = 1'b0;
        w_anyNext   = 1'b0;
        for (int i = 0; i < NUM_GPR; i++) begin
            w_gprSum[i] = SUM_W'(r_gprCnt[i]) + SUM_W'(w_issue && r_rdWe && (r_rd == GPR_AW'(i)) && (i != 0));
            if (w_gprSum[i] < SUM_W'(w_gprDec[i])) begin
                w_gprNext[i] = '0;
                w_underflow  = 1'b1;
            end else begin
                w_gprNext[i] = PEND_W'(w_gprSum[i] - SUM_W'(w_gprDec[i]));
            end
            w_anyNext = w_anyNext | (w_gprNext[i] != '0);
        end
        for (int i = 0; i < NUM_CSR; i++) begin
            w_csrSum[i] = SUM_W'(r_csrCnt[i]) + SUM_W'(w_issue && r_csrWe && (r_csrRd == CSR_AW'(i)));
            if (w_csrSum[i] < SUM_W'(w_csrDec[i])) begin
                w_csrNext[i] = '0;
                w_underflow  = 1'b1;
            end else begin
                w_csrNext[i] = PEND_W'(w_csrSum[i] - SUM_W'(w_csrDec[i]));
            end
            w_anyNext = w_anyNext | (w_csrNext[i] != '0);
        end
    end

    // Counts seen by the hazard check: optionally net out this cycle's retires.
    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) begin
`ifdef WB_BYPASS_EN
            w_gprEff[i] = (SUM_W'(r_gprCnt[i]) > SUM_W'(w_gprDec[i])) ?
                          PEND_W'(SUM_W'(r_gprCnt[i]) - SUM_W'(w_gprDec[i])) : '0;
`else
            w_gprEff[i] = r_gprCnt[i];
`endif
        end
        for (int i = 0; i < NUM_CSR; i++) begin
`ifdef WB_BYPASS_EN
            w_csrEff[i] = (SUM_W'(r_csrCnt[i]) > SUM_W'(w_csrDec[i])) ?
                          PEND_W'(SUM_W'(r_csrCnt[i]) - SUM_W'(w_csrDec[i])) : '0;
`else
            w_csrEff[i] = r_csrCnt[i];
`endif
        end
    end

    assign w_hazard = (r_rs1Used   && (r_rs1 != '0) && (w_gprEff[r_rs1] != '0))
                   || (r_rs2Used   && (r_rs2 != '0) && (w_gprEff[r_rs2] != '0))
                   || (r_csrRsUsed && (w_csrEff[r_csrRs] != '0))
                   || (r_rdWe      && (r_rd != '0)  && (w_gprEff[r_rd] == CNT_MAX))
                   || (r_csrWe     && (w_csrEff[r_csrRd] == CNT_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPR; i++) r_gprCnt[i] <= '0;
            for (int i = 0; i < NUM_CSR; i++) r_csrCnt[i] <= '0;
            r_sbBusy  <= 1'b0;
            r_sbError <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) r_gprCnt[i] <= w_gprNext[i];
            for (int i = 0; i < NUM_CSR; i++) r_csrCnt[i] <= w_csrNext[i];
            r_sbBusy <= w_anyNext;
            if (w_underflow) r_sbError <= 1'b1;
        end
    end

    // Flush wins over issue and capture; the scoreboard itself is left alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_outValid    <= 1'b0;
            r_payload     <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rs1Used     <= 1'b0;
            r_rs2Used     <= 1'b0;
            r_rd          <= '0;
            r_rdWe        <= 1'b0;
            r_csrRs       <= '0;
            r_csrRsUsed   <= 1'b0;
            r_csrRd       <= '0;
            r_csrWe       <= 1'b0;
            r_stallCycles <= '0;
        end else if (flush) begin
            r_state    <= S_IDLE;
            r_outValid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_payload   <= in_payload;
                r_rs1       <= in_rs1;
                r_rs2       <= in_rs2;
                r_rs1Used   <= in_rs1_used;
                r_rs2Used   <= in_rs2_used;
                r_rd        <= in_rd;
                r_rdWe      <= in_rd_we;
                r_csrRs     <= in_csr_rs;
                r_csrRsUsed <= in_csr_rs_used;
                r_csrRd     <= in_csr_rd;
                r_csrWe     <= in_csr_we;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_capture) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!w_hazard) begin
                        r_state    <= S_VALID;
                        r_outValid <= 1'b1;
                    end else begin
                        r_stallCycles <= r_stallCycles + 32'd1;
                    end
                end
                S_VALID: begin
                    if (w_issue) begin
                        r_state    <= w_capture ? S_WAIT : S_IDLE;
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = w_inReady;
    assign out_valid    = r_outValid;
    assign out_payload  = r_payload;
    assign out_rd       = r_rd;
    assign out_rd_we    = r_rdWe;
    assign out_csr_rd   = r_csrRd;
    assign out_csr_we   = r_csrWe;
    assign sb_busy      = r_sbBusy;
    assign sb_error     = r_sbError;
    assign stall_cycles = r_stallCycles;

endmodule

// File: doc/idu_issue_scoreboard.md
Name: idu_issue_scoreboard

Overview:
- Parametrised decode-to-execute issue stage.
- Replaces fixed per-unit rd/csr_rd compare hazard checks with a per-register pending-write scoreboard.
- Scoreboard covers a configurable number of GPRs and CSRs and accepts a configurable number of writeback retire channels.
- Sits between the decoder and EXU: captures one decoded instruction, stalls it until all of its sources are clean, then issues it with a valid/ready handshake.

Parameters:
- GPR_AW, 5, GPR index width; NUM_GPR = 2**GPR_AW; register 0 is never tracked.
- CSR_AW, 2, CSR index width; NUM_CSR = 2**CSR_AW; all CSRs are tracked.
- NUM_WB, 2, number of writeback retire channels.
- PEND_W, 2, per-register pending counter width; at most 2**PEND_W-1 writes may be in flight to one register.
- PAYLOAD_W, 64, opaque payload width ({pc, instruction}), passed through unmodified.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decoder offers an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_payload  in  PAYLOAD_W  pc/instruction
- in_rs1, in_rs2  in  GPR_AW  source GPR indices
- in_rs1_used, in_rs2_used  in  1  source is actually read
- in_rd  in  GPR_AW  destination GPR
- in_rd_we  in  1  instruction writes a GPR
- in_csr_rs  in  CSR_AW  source CSR
- in_csr_rs_used  in  1  CSR is read
- in_csr_rd  in  CSR_AW  destination CSR
- in_csr_we  in  1  instruction writes a CSR
- out_valid  out  1  issue offer to EXU
- out_ready  in  1  EXU accepts
- out_payload  out  PAYLOAD_W  held payload
- out_rd  out  GPR_AW  held destination GPR
- out_rd_we  out  1  held GPR write enable
- out_csr_rd  out  CSR_AW  held destination CSR
- out_csr_we  out  1  held CSR write enable
- wb_gpr_valid  in  NUM_WB  per-channel GPR retire
- wb_gpr_rd  in  NUM_WB*GPR_AW  retired GPR index, channel i at [i*GPR_AW +: GPR_AW]
- wb_csr_valid  in  NUM_WB  per-channel CSR retire
- wb_csr_rd  in  NUM_WB*CSR_AW  retired CSR index
- flush  in  1  drop the held instruction
- sb_busy  out  1  any pending counter nonzero
- sb_error  out  1  sticky: retire seen at count 0
- stall_cycles  out  32  count of hazard-stalled cycles, wraps

Behaviour:
- Reset: state IDLE; all counters 0; out_valid=0; out_* payload/fields=0; sb_busy=0; sb_error=0; stall_cycles=0. in_ready=0 while rst is high.
- States: IDLE, WAIT, VALID.
- in_ready = !rst && (IDLE || (VALID && out_ready)).
- Capture: on in_valid && in_ready, all in_* fields are registered into the hold register, and the state goes to WAIT. This applies from IDLE and from VALID; issue and capture in the same cycle gives 1 instruction per 2 cycles.
- Hazard in WAIT: hazard = any of the following:
  - rs1_used && rs1 != 0 && gpr_cnt[rs1] != 0
  - rs2_used && rs2 != 0 && gpr_cnt[rs2] != 0
  - csr_rs_used && csr_cnt[csr_rs] != 0
  - rd_we && rd != 0 && gpr_cnt[rd] == max
  - csr_we && csr_cnt[csr_rd] == max
- Counts used by the hazard check: see WB_BYPASS_EN.
- WAIT: if no hazard, go to VALID (out_valid=1 next cycle). Otherwise stay in WAIT and increment stall_cycles.
- VALID: out_valid=1 and outputs stable until the handshake. On out_valid && out_ready:
  - increment gpr_cnt[rd] if rd_we && rd != 0;
  - increment csr_cnt[csr_rd] if csr_we;
  - go to WAIT if a capture happens the same cycle, else IDLE.
- Counter update per cycle: new = old + issue_inc − (number of wb channels retiring that index this cycle).
  - Multiple channels retiring the same index subtract multiply.
  - An increment and a decrement in the same cycle to the same index net out.
  - A retire to GPR 0 is ignored.
- Underflow: decrements beyond 0 clamp at 0 and set sb_error (sticky until rst).
- Saturation: never occurs, because issue is blocked at max.
- flush (priority over capture and issue): state goes to IDLE and out_valid drops next cycle. The held instruction is not counted and is not issued. The scoreboard is not cleared, so in-flight writes still retire. in_ready=0 during the flush cycle.
- sb_busy is registered: OR of all counters after update.

Optional Feature:
- WB_BYPASS_EN defined:
  - Hazard check uses count minus same-cycle retires to that index.
  - A source whose last pending write retires this cycle is clean, and the instruction reaches VALID the next cycle.
- Undefined:
  - Hazard check uses registered counts only.
  - One extra WAIT cycle after the final retire.

Test Plan:
1. Reset, then in_valid with rs1=3 and an empty scoreboard, out_ready=1 → out_valid 2 cycles after capture; out_payload equals input; gpr_cnt[3]=0; stall_cycles=0.
2. Issue A (rd=5, we=1), then B (rs1=5) → B stalls; retire wb_gpr_rd=5 on ch0 at cycle T → B out_valid at T+1 with bypass, T+2 without; stall_cycles equals WAIT cycles.
3. Issue 3 writes to rd=7 (PEND_W=2, none retired), then a 4th → 4th held in WAIT. A single retire of 7 → 4th issues; gpr_cnt[7] returns to 3.
4. Both channels retire rd=9 when gpr_cnt[9]=2, same cycle → count 0, sb_busy=0 next cycle. Retire 9 again → sb_error=1 and stays 1.
5. Instruction in VALID with out_ready=0 for 5 cycles → outputs stable. Then flush=1 → out_valid=0 next cycle, rd counter unchanged, in_ready=1 the following cycle.
6. Writer with rd=0 and we=1 issued → no counter changes, sb_busy=0. Reader with rs1=0 never stalls.
